// File: rtl/data_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_fetch_unit_if
//  Description : BRAM port B bundle between the data fetch unit (master)
//                and the block RAM (slave).
//                  addrb : byte address (word index * 4)
//                  dinb  : write data
//                  enb   : port enable
//                  web   : byte write enables
//                  doutb : read data, one cycle after the address
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_fetch_unit_if;
    logic [31:0] addrb;
    logic [31:0] dinb;
    logic        enb;
    logic [3:0]  web;
    logic [31:0] doutb;

    modport master (output addrb, output dinb, output enb, output web, input doutb);
    modport slave  (input addrb, input dinb, input enb, input web, output doutb);
endinterface
`default_nettype wire

// File: rtl/data_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : data_fetch_unit
//  Description : Loads one 2x2 tile of a 2x2/4x4/8x8 row-major matrix from
//                BRAM port B into the four PE operand registers, or stores the
//                four PE results back as a 2x2 tile.
//  Ports       : CLK, ADDR_RST (async, active high)
//                ADDR_START / WRADDR_START : load / store request (store wins)
//                DIMEN, ADDRESS, PE_SEL, PE_SEL_2x2, PE_SEL_4 : tile select
//                PE_DOUT_0..3 : data to store
//                PE_DIN_0..3  : loaded operands
//                FETCH_DONE / STORE_DONE : one-cycle completion pulses
//                bram : BRAM port B (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_fetch_unit (
    input  wire logic        CLK,
    input  wire logic        ADDR_RST,
    input  wire logic        ADDR_START,
    input  wire logic        WRADDR_START,
    input  wire logic [1:0]  DIMEN,
    input  wire logic [3:0]  ADDRESS,
    input  wire logic [1:0]  PE_SEL,
    input  wire logic        PE_SEL_2x2,
    input  wire logic        PE_SEL_4,
    input  wire logic [31:0] PE_DOUT_0,
    input  wire logic [31:0] PE_DOUT_1,
    input  wire logic [31:0] PE_DOUT_2,
    input  wire logic [31:0] PE_DOUT_3,
    output logic [31:0]      PE_DIN_0,
    output logic [31:0]      PE_DIN_1,
    output logic [31:0]      PE_DIN_2,
    output logic [31:0]      PE_DIN_3,
    output logic             FETCH_DONE,
    output logic             STORE_DONE,
    data_fetch_unit_if.master bram
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD0   = 4'd1,
        S_RD1   = 4'd2,
        S_RD2   = 4'd3,
        S_RD3   = 4'd4,
        S_RDW   = 4'd5,
        S_FDONE = 4'd6,
        S_WR0   = 4'd7,
        S_WR1   = 4'd8,
        S_WR2   = 4'd9,
        S_WR3   = 4'd10,
        S_SDONE = 4'd11
    } state_t;

    state_t      r_state, w_state_nxt;

    // Operation parameters captured in IDLE
    logic [1:0]  r_shift, r_tr, r_tc;
    logic [3:0]  r_address;
    logic [31:0] r_dout [4];

    logic        w_latch, w_latch_dout;
    logic [1:0]  w_shift_in, w_tr_in, w_tc_in;
    logic [1:0]  w_shift_nxt, w_tr_nxt, w_tc_nxt;
    logic [3:0]  w_address_nxt;
    logic [31:0] w_pe_dout_in [4];
    logic [31:0] w_dout_nxt   [4];

    logic [1:0]  w_k;
    logic        w_en, w_wr;
    logic [2:0]  w_row, w_col;
    logic [9:0]  w_word;
    logic [31:0] w_addrb_nxt, w_dinb_nxt;
    logic [3:0]  w_web_nxt;

    logic [31:0] r_addrb, r_dinb;
    logic        r_enb;
    logic [3:0]  r_web;

    assign w_pe_dout_in[0] = PE_DOUT_0;
    assign w_pe_dout_in[1] = PE_DOUT_1;
    assign w_pe_dout_in[2] = PE_DOUT_2;
    assign w_pe_dout_in[3] = PE_DOUT_3;

    // Matrix side as log2(N) and tile coordinates from the live inputs
    always_comb begin
        w_shift_in = 2'd3;
        w_tr_in    = {PE_SEL_4, PE_SEL[1]};
        w_tc_in    = {PE_SEL_2x2, PE_SEL[0]};
        case (DIMEN)
            2'b00: begin
                w_shift_in = 2'd1;
                w_tr_in    = 2'd0;
                w_tc_in    = 2'd0;
            end
            2'b01: begin
                w_shift_in = 2'd2;
                w_tr_in    = {1'b0, PE_SEL_4};
                w_tc_in    = {1'b0, PE_SEL_2x2};
            end
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_latch_dout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (WRADDR_START) begin
                    w_state_nxt  = S_WR0;
                    w_latch      = 1'b1;
                    w_latch_dout = 1'b1;
                end else if (ADDR_START) begin
                    w_state_nxt  = S_RD0;
                    w_latch      = 1'b1;
                end
            end
            S_RD0:   w_state_nxt = S_RD1;
            S_RD1:   w_state_nxt = S_RD2;
            S_RD2:   w_state_nxt = S_RD3;
            S_RD3:   w_state_nxt = S_RDW;
            S_RDW:   w_state_nxt = S_FDONE;
            S_FDONE: w_state_nxt = S_IDLE;
            S_WR0:   w_state_nxt = S_WR1;
            S_WR1:   w_state_nxt = S_WR2;
            S_WR2:   w_state_nxt = S_WR3;
            S_WR3:   w_state_nxt = S_SDONE;
            S_SDONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Parameters as they will be after this edge, so the first bus cycle
    // of an operation can already use the freshly sampled inputs.
    always_comb begin
        w_shift_nxt   = w_latch ? w_shift_in : r_shift;
        w_tr_nxt      = w_latch ? w_tr_in    : r_tr;
        w_tc_nxt      = w_latch ? w_tc_in    : r_tc;
        w_address_nxt = w_latch ? ADDRESS    : r_address;
        for (int i = 0; i < 4; i++) begin
            w_dout_nxt[i] = w_latch_dout ? w_pe_dout_in[i] : r_dout[i];
        end
    end

    // Registered bus outputs, decoded from the next state
    always_comb begin
        w_k  = 2'd0;
        w_en = 1'b0;
        w_wr = 1'b0;
        case (w_state_nxt)
            S_RD0: begin w_en = 1'b1; w_k = 2'd0; end
            S_RD1: begin w_en = 1'b1; w_k = 2'd1; end
            S_RD2: begin w_en = 1'b1; w_k = 2'd2; end
            S_RD3: begin w_en = 1'b1; w_k = 2'd3; end
            S_WR0: begin w_en = 1'b1; w_wr = 1'b1; w_k = 2'd0; end
            S_WR1: begin w_en = 1'b1; w_wr = 1'b1; w_k = 2'd1; end
            S_WR2: begin w_en = 1'b1; w_wr = 1'b1; w_k = 2'd2; end
            S_WR3: begin w_en = 1'b1; w_wr = 1'b1; w_k = 2'd3; end
            default: ;
        endcase
        // word = ADDRESS*64 + (2*TR + r)*N + 2*TC + c
        w_row       = {w_tr_nxt, w_k[1]};
        w_col       = {w_tc_nxt, w_k[0]};
        w_word      = {w_address_nxt, 6'd0} + (10'(w_row) << w_shift_nxt) + 10'(w_col);
        w_addrb_nxt = w_en ? {20'd0, w_word, 2'b00} : 32'd0;
        w_dinb_nxt  = w_wr ? w_dout_nxt[w_k] : 32'd0;
        w_web_nxt   = w_wr ? 4'hF : 4'h0;
    end

    always_ff @(posedge CLK or posedge ADDR_RST) begin
        if (ADDR_RST) begin
            r_state    <= S_IDLE;
            r_shift    <= 2'd0;
            r_tr       <= 2'd0;
            r_tc       <= 2'd0;
            r_address  <= 4'd0;
            for (int i = 0; i < 4; i++) r_dout[i] <= 32'd0;
            r_addrb    <= 32'd0;
            r_dinb     <= 32'd0;
            r_enb      <= 1'b0;
            r_web      <= 4'h0;
            PE_DIN_0   <= 32'd0;
            PE_DIN_1   <= 32'd0;
            PE_DIN_2   <= 32'd0;
            PE_DIN_3   <= 32'd0;
            FETCH_DONE <= 1'b0;
            STORE_DONE <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_tr       <= w_tr_nxt;
            r_tc       <= w_tc_nxt;
            r_address  <= w_address_nxt;
            for (int i = 0; i < 4; i++) r_dout[i] <= w_dout_nxt[i];
            r_addrb    <= w_addrb_nxt;
            r_dinb     <= w_dinb_nxt;
            r_enb      <= w_en;
            r_web      <= w_web_nxt;
            FETCH_DONE <= (w_state_nxt == S_FDONE);
            STORE_DONE <= (w_state_nxt == S_SDONE);
            // BRAM data for element k arrives one state after RDk
            case (r_state)
                S_RD1:   PE_DIN_0 <= bram.doutb;
                S_RD2:   PE_DIN_1 <= bram.doutb;
                S_RD3:   PE_DIN_2 <= bram.doutb;
                S_RDW:   PE_DIN_3 <= bram.doutb;
                default: ;
            endcase
        end
    end

    assign bram.addrb = r_addrb;
    assign bram.dinb  = r_dinb;
    assign bram.enb   = r_enb;
    assign bram.web   = r_web;

endmodule
`default_nettype wire

// File: tb/tb_data_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_fetch_unit
//  Description : Directed self-checking bench for data_fetch_unit. The BRAM
//                model returns 100 + word index with one cycle of latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_fetch_unit;

    logic        CLK = 1'b0;
    logic        ADDR_RST = 1'b1;
    logic        ADDR_START = 1'b0;
    logic        WRADDR_START = 1'b0;
    logic [1:0]  DIMEN = 2'b00;
    logic [3:0]  ADDRESS = 4'd0;
    logic [1:0]  PE_SEL = 2'b00;
    logic        PE_SEL_2x2 = 1'b0;
    logic        PE_SEL_4 = 1'b0;
    logic [31:0] PE_DOUT_0 = 32'd0, PE_DOUT_1 = 32'd0, PE_DOUT_2 = 32'd0, PE_DOUT_3 = 32'd0;
    logic [31:0] PE_DIN_0, PE_DIN_1, PE_DIN_2, PE_DIN_3;
    logic        FETCH_DONE, STORE_DONE;

    int n_checks = 0;
    int n_fail   = 0;

    data_fetch_unit_if bus ();

    data_fetch_unit u_dut (
        .CLK          (CLK),
        .ADDR_RST     (ADDR_RST),
        .ADDR_START   (ADDR_START),
        .WRADDR_START (WRADDR_START),
        .DIMEN        (DIMEN),
        .ADDRESS      (ADDRESS),
        .PE_SEL       (PE_SEL),
        .PE_SEL_2x2   (PE_SEL_2x2),
        .PE_SEL_4     (PE_SEL_4),
        .PE_DOUT_0    (PE_DOUT_0),
        .PE_DOUT_1    (PE_DOUT_1),
        .PE_DOUT_2    (PE_DOUT_2),
        .PE_DOUT_3    (PE_DOUT_3),
        .PE_DIN_0     (PE_DIN_0),
        .PE_DIN_1     (PE_DIN_1),
        .PE_DIN_2     (PE_DIN_2),
        .PE_DIN_3     (PE_DIN_3),
        .FETCH_DONE   (FETCH_DONE),
        .STORE_DONE   (STORE_DONE),
        .bram         (bus.master)
    );

    always #5 CLK = ~CLK;

    // BRAM read model: 1-cycle latency, content = 100 + word index
    initial bus.doutb = 32'd0;
    always @(posedge CLK) begin
        if (bus.enb && bus.web == 4'h0)
            bus.doutb <= 32'd100 + (bus.addrb >> 2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_enb"},   32'(bus.enb),   32'd0);
        check({tag, "_web"},   32'(bus.web),   32'd0);
        check({tag, "_addrb"}, bus.addrb,      32'd0);
        check({tag, "_dinb"},  bus.dinb,       32'd0);
    endtask

    // Runs one load from IDLE; w0..w3 are the hand-computed word indices.
    task automatic run_load(input string nm, input logic [1:0] dim, input logic [3:0] adr,
                            input logic [1:0] sel, input logic s2, input logic s4,
                            input int w0, input int w1, input int w2, input int w3);
        int w[4];
        w = '{w0, w1, w2, w3};
        DIMEN = dim; ADDRESS = adr; PE_SEL = sel; PE_SEL_2x2 = s2; PE_SEL_4 = s4;
        ADDR_START = 1'b1;
        tick();                        // cycle 1
        ADDR_START = 1'b0;
        // selects changed mid-operation must be ignored
        ADDRESS = ~adr; PE_SEL = ~sel; PE_SEL_2x2 = ~s2; PE_SEL_4 = ~s4; DIMEN = ~dim;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_rd%0d_addrb", nm, k), bus.addrb, 32'(w[k] * 4));
            check($sformatf("%s_rd%0d_enb", nm, k), 32'(bus.enb), 32'd1);
            check($sformatf("%s_rd%0d_web", nm, k), 32'(bus.web), 32'd0);
            check($sformatf("%s_rd%0d_fd", nm, k), 32'(FETCH_DONE), 32'd0);
            tick();
        end
        check_idle_bus({nm, "_rdw"});  // cycle 5
        check({nm, "_rdw_fd"}, 32'(FETCH_DONE), 32'd0);
        tick();                        // cycle 6
        check({nm, "_fd"}, 32'(FETCH_DONE), 32'd1);
        check({nm, "_din0"}, PE_DIN_0, 32'(100 + w[0]));
        check({nm, "_din1"}, PE_DIN_1, 32'(100 + w[1]));
        check({nm, "_din2"}, PE_DIN_2, 32'(100 + w[2]));
        check({nm, "_din3"}, PE_DIN_3, 32'(100 + w[3]));
        tick();                        // cycle 7
        check({nm, "_fd_end"}, 32'(FETCH_DONE), 32'd0);
    endtask

    logic [6:0] bus_vec;
    logic [6:0] exp_vec [13];
    logic [31:0] din_save [4];

    initial begin
        // ---------------- reset state ----------------
        #1;
        check_idle_bus("rst");
        check("rst_din0", PE_DIN_0, 32'd0);
        check("rst_din3", PE_DIN_3, 32'd0);
        check("rst_fd", 32'(FETCH_DONE), 32'd0);
        check("rst_sd", 32'(STORE_DONE), 32'd0);
        tick();
        ADDR_RST = 1'b0;
        tick();

        // ---------------- loads ----------------
        run_load("l2x2", 2'b00, 4'd0, 2'b00, 1'b0, 1'b0, 0, 1, 2, 3);
        run_load("l4x4", 2'b01, 4'd0, 2'b00, 1'b1, 1'b1, 10, 11, 14, 15);
        run_load("l8x8", 2'b10, 4'd1, 2'b11, 1'b0, 1'b1, 114, 115, 122, 123);
        run_load("l8x8d3", 2'b11, 4'd1, 2'b11, 1'b0, 1'b1, 114, 115, 122, 123);

        // ---------------- 2x2 store ----------------
        din_save = '{PE_DIN_0, PE_DIN_1, PE_DIN_2, PE_DIN_3};
        DIMEN = 2'b00; ADDRESS = 4'd0;
        PE_DOUT_0 = 32'd45; PE_DOUT_1 = 32'd46; PE_DOUT_2 = 32'd47; PE_DOUT_3 = 32'd48;
        WRADDR_START = 1'b1;
        tick();                        // cycle 1
        WRADDR_START = 1'b0;
        PE_DOUT_0 = 32'd0; PE_DOUT_1 = 32'd0; PE_DOUT_2 = 32'd0; PE_DOUT_3 = 32'd0;
        ADDRESS = 4'd7;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("st_wr%0d_addrb", k), bus.addrb, 32'(k * 4));
            check($sformatf("st_wr%0d_dinb", k), bus.dinb, 32'(45 + k));
            check($sformatf("st_wr%0d_web", k), 32'(bus.web), 32'hF);
            check($sformatf("st_wr%0d_enb", k), 32'(bus.enb), 32'd1);
            check($sformatf("st_wr%0d_sd", k), 32'(STORE_DONE), 32'd0);
            tick();
        end
        check("st_sd", 32'(STORE_DONE), 32'd1);   // cycle 5
        check_idle_bus("st_sdone");
        tick();
        check("st_sd_end", 32'(STORE_DONE), 32'd0);
        check("st_din0_kept", PE_DIN_0, din_save[0]);
        check("st_din1_kept", PE_DIN_1, din_save[1]);
        check("st_din2_kept", PE_DIN_2, din_save[2]);
        check("st_din3_kept", PE_DIN_3, din_save[3]);

        // ---------------- reset in RD2 ----------------
        DIMEN = 2'b00; ADDRESS = 4'd0;
        ADDR_START = 1'b1;
        tick();                        // RD0
        ADDR_START = 1'b0;
        tick();                        // RD1
        tick();                        // RD2, PE_DIN_0 just loaded
        check("mr_din0_loaded", PE_DIN_0, 32'd100);
        ADDR_RST = 1'b1;
        #1;
        check_idle_bus("mr");
        check("mr_din0", PE_DIN_0, 32'd0);
        check("mr_din1", PE_DIN_1, 32'd0);
        check("mr_din2", PE_DIN_2, 32'd0);
        check("mr_din3", PE_DIN_3, 32'd0);
        check("mr_fd", 32'(FETCH_DONE), 32'd0);
        check("mr_sd", 32'(STORE_DONE), 32'd0);
        tick();
        ADDR_RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("mr_post%0d_fd", c), 32'(FETCH_DONE), 32'd0);
            check($sformatf("mr_post%0d_enb", c), 32'(bus.enb), 32'd0);
        end

        // ---------------- both requests high ----------------
        // {enb, web[3:0], STORE_DONE, FETCH_DONE} per cycle 1..13
        exp_vec = '{7'b1111100, 7'b1111100, 7'b1111100, 7'b1111100,
                    7'b0000010, 7'b0000000,
                    7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                    7'b0000000, 7'b0000001, 7'b0000000};
        DIMEN = 2'b00; ADDRESS = 4'd2;
        PE_DOUT_0 = 32'd1; PE_DOUT_1 = 32'd2; PE_DOUT_2 = 32'd3; PE_DOUT_3 = 32'd4;
        ADDR_START = 1'b1;
        WRADDR_START = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) WRADDR_START = 1'b0;
            if (c == 7) ADDR_START = 1'b0;
            bus_vec = {bus.enb, bus.web, STORE_DONE, FETCH_DONE};
            check($sformatf("both_c%0d", c), 32'(bus_vec), 32'(exp_vec[c-1]));
        end
        check("both_din0", PE_DIN_0, 32'd228);   // 100 + 2*64
        check("both_din3", PE_DIN_3, 32'd231);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
